// File: rtl/num_str_tx.sv
// ---------------------------------------------------------------------------
// num_str_tx
// Formats a captured sign + four ASCII digits (or an "ERR" marker) into a
// byte stream for a UART transmitter using a valid/ready handshake.
//
// Parameters:
//   LZ_BLANK        1: leading '0' digits (except the last) are sent as ' '
//                   0: digits are sent unchanged
// Configuration macro:
//   NUM_STR_TX_CRLF_EN  when defined, every frame is terminated by CR LF
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-high reset
//   start            request one frame (sampled only in IDLE)
//   signbuffer       ASCII sign character
//   outputValBuffer  four ASCII digits, [31:24] most significant
//   validout         1 = digits valid, 0 = send "ERR"
//   tx_data          byte offered to the transmitter
//   tx_valid         tx_data valid, held until accepted
//   tx_ready         transmitter accepts on tx_valid && tx_ready
//   busy             high from start acceptance through the done cycle
//   done             one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module num_str_tx #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  signbuffer,
    input  logic [31:0] outputValBuffer,
    input  logic        validout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef NUM_STR_TX_CRLF_EN
    localparam logic [2:0] VALID_LAST   = 3'd6;
    localparam logic [2:0] INVALID_LAST = 3'd4;
`else
    localparam logic [2:0] VALID_LAST   = 3'd4;
    localparam logic [2:0] INVALID_LAST = 3'd2;
`endif

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sign_q, sign_d;
    logic [31:0] digits_q, digits_d;
    logic        valid_q, valid_d;

    logic [2:0]  last_idx_s;
    logic        zero3_s, zero2_s, zero1_s;
    logic [7:0]  sel_byte_s;

    // Replace a digit by a space when it belongs to the leading-zero run.
    function automatic logic [7:0] blank_digit(input logic [7:0] dig, input logic in_zero_run);
        if (LZ_BLANK && in_zero_run) begin
            blank_digit = 8'h20;
        end else begin
            blank_digit = dig;
        end
    endfunction

    // A digit is blanked only if it and every more significant digit are '0'.
    assign zero3_s = (digits_q[31:24] == 8'h30);
    assign zero2_s = zero3_s && (digits_q[23:16] == 8'h30);
    assign zero1_s = zero2_s && (digits_q[15:8]  == 8'h30);

    assign last_idx_s = valid_q ? VALID_LAST : INVALID_LAST;

    // Select the byte for the current index from the captured frame contents.
    always_comb begin
        sel_byte_s = 8'h00;
        if (valid_q) begin
            case (idx_q)
                3'd0:    sel_byte_s = sign_q;
                3'd1:    sel_byte_s = blank_digit(digits_q[31:24], zero3_s);
                3'd2:    sel_byte_s = blank_digit(digits_q[23:16], zero2_s);
                3'd3:    sel_byte_s = blank_digit(digits_q[15:8],  zero1_s);
                3'd4:    sel_byte_s = digits_q[7:0];
                3'd5:    sel_byte_s = 8'h0D;
                3'd6:    sel_byte_s = 8'h0A;
                default: sel_byte_s = 8'h00;
            endcase
        end else begin
            case (idx_q)
                3'd0:    sel_byte_s = 8'h45;
                3'd1:    sel_byte_s = 8'h52;
                3'd2:    sel_byte_s = 8'h52;
                3'd3:    sel_byte_s = 8'h0D;
                3'd4:    sel_byte_s = 8'h0A;
                default: sel_byte_s = 8'h00;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign tx_valid = (state_q == SEND);
    assign tx_data  = (state_q == SEND) ? sel_byte_s : 8'h00;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    // Next-state, byte index and capture logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sign_d   = sign_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    idx_d    = 3'd0;
                    sign_d   = signbuffer;
                    digits_d = outputValBuffer;
                    valid_d  = validout;
                end else begin
                    state_d  = IDLE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == last_idx_s) begin
                        state_d = DONE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, index and captured-frame registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            sign_q   <= 8'h00;
            digits_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sign_q   <= sign_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_num_str_tx.sv
module tb_num_str_tx;

    localparam bit LZ = 1'b1;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  signbuffer;
    logic [31:0] outputValBuffer;
    logic        validout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    num_str_tx #(.LZ_BLANK(LZ)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .signbuffer      (signbuffer),
        .outputValBuffer (outputValBuffer),
        .validout        (validout),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare an observed value against its expectation and record the result.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the byte sequence a frame must produce.
    task automatic build_expected(input logic [7:0] s, input logic [31:0] d, input logic v);
        logic       lead;
        logic [7:0] dig;
        exp_q = {};
        if (v) begin
            exp_q.push_back(s);
            lead = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                dig = d[i*8 +: 8];
                if (LZ && lead && dig == 8'h30 && i != 0) begin
                    exp_q.push_back(8'h20);
                end else begin
                    exp_q.push_back(dig);
                    lead = 1'b0;
                end
            end
        end else begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h52);
            exp_q.push_back(8'h52);
        end
`ifdef NUM_STR_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    function automatic logic [31:0] rand_digits();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(1, 0) == 1) r[i*8 +: 8] = 8'h30;
            else                           r[i*8 +: 8] = 8'h30 + 8'($urandom_range(9, 0));
        end
        return r;
    endfunction

    // Runs one frame; called at a negedge. mode: 0 ready=1, 1 pattern 1,0,0,1,0,1, 2 random.
    task automatic run_frame(input logic [7:0] s, input logic [31:0] d, input logic v,
                             input int mode, input bit inject, input bit start_in_done);
        int k;
        int cyc;
        int pat;
        build_expected(s, d, v);
        signbuffer      = s;
        outputValBuffer = d;
        validout        = v;
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start           = 1'b0;
        signbuffer      = 8'($urandom);
        outputValBuffer = $urandom;
        validout        = 1'($urandom);
        k   = 0;
        cyc = 0;
        pat = 0;
        while (k < exp_q.size() && cyc < 200) begin
            check("tx_valid", 32'(tx_valid), 32'd1);
            check("tx_data", 32'(tx_data), 32'(exp_q[k]));
            check("busy_send", 32'(busy), 32'd1);
            check("done_send", 32'(done), 32'd0);
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (pat % 6 == 0 || pat % 6 == 3 || pat % 6 == 5);
                default: tx_ready = 1'($urandom);
            endcase
            pat++;
            start = inject ? 1'($urandom) : 1'b0;
            @(posedge clk);
            if (tx_ready) k++;
            @(negedge clk);
            cyc++;
        end
        check("frame_complete", 32'(k), 32'(exp_q.size()));
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        check("tx_valid_done", 32'(tx_valid), 32'd0);
        if (start_in_done) begin
            start           = 1'b1;
            signbuffer      = 8'h2D;
            outputValBuffer = 32'h3939_3939;
            validout        = 1'b1;
        end
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("tx_valid_idle", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        signbuffer      = 8'h00;
        outputValBuffer = 32'h0;
        validout        = 1'b0;
        tx_ready        = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed frames from the reference examples.
        run_frame(8'h2B, 32'h3132_3334, 1'b1, 0, 1'b0, 1'b0);
        run_frame(8'h2D, 32'h3030_3037, 1'b1, 0, 1'b0, 1'b0);
        run_frame(8'h2B, 32'h3030_3030, 1'b1, 0, 1'b0, 1'b0);
        run_frame(8'h2B, 32'h3031_3030, 1'b1, 0, 1'b0, 1'b0);
        run_frame(8'h2B, 32'h3132_3334, 1'b0, 0, 1'b0, 1'b0);
        // Stall pattern with start pulses during busy.
        run_frame(8'h2D, 32'h3930_3031, 1'b1, 1, 1'b1, 1'b0);
        run_frame(8'h2B, 32'h3030_3030, 1'b0, 1, 1'b1, 1'b0);
        // Start held in DONE is ignored; accepted in following IDLE.
        run_frame(8'h2B, 32'h3035_3030, 1'b1, 0, 1'b0, 1'b1);
        run_frame(8'h2D, 32'h3939_3939, 1'b1, 0, 1'b0, 1'b0);

        // Randomized frames.
        for (int n = 0; n < 20; n++) begin
            run_frame(($urandom_range(1, 0) == 1) ? 8'h2B : 8'h2D, rand_digits(),
                      ($urandom_range(3, 0) != 0), 2, 1'($urandom), 1'b0);
        end

        // Asynchronous reset after two handshakes.
        signbuffer      = 8'h2B;
        outputValBuffer = 32'h3132_3334;
        validout        = 1'b1;
        start           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'h00);
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame(8'h2B, 32'h3132_3334, 1'b1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
